// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO definitions used by the write-side and read-side
// pointer logic.
//   ADDRSIZE_DEF : default log2 of FIFO depth
//   bin2gray     : binary -> reflected Gray code (operates on up to 32 bits)
//   gray2bin     : reflected Gray code -> binary (operates on up to 32 bits)
// Callers zero-extend narrower pointers into the 32-bit argument and
// truncate the result back to their own width.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEF = 4;
  localparam int unsigned CODE_W       = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
    logic [CODE_W-1:0] bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// sync_r2w: two-flop synchronizer bringing the Gray read pointer into the
// write clock domain.
//   wclk     : write-domain clock
//   wrst     : synchronous active-high reset (clears both flops)
//   rptr     : Gray read pointer, asynchronous to wclk
//   wq2_rptr : read pointer after two wclk flops
module sync_r2w
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [ADDRSIZE:0] rptr,
  output logic [ADDRSIZE:0] wq2_rptr
);

  logic [ADDRSIZE:0] wq1_rptr;

  // Flop-to-flop with nothing in between; Gray coding keeps the sampled
  // value within one step of the true pointer.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer and full/level logic of an async FIFO.
//   wclk         : write-domain clock (only clock)
//   wrst         : synchronous active-high reset
//   winc         : write request, accepted only while not full
//   rptr         : Gray read pointer from the read domain
//   wovf_clr     : clears the sticky overflow flag
//   waddr        : binary write address into the storage array
//   wptr         : registered Gray write pointer for the read domain
//   wfull        : registered full flag
//   walmost_full : registered level >= AFULL_THRESH
//   wlevel       : registered occupancy seen from the write domain
//   wovf         : sticky overflow flag
// Build option: define WPTR_FULL_OVF_EN to include the overflow register;
// otherwise wovf is constant 0 and wovf_clr is ignored.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = ADDRSIZE_DEF,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbnext;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] full_gray;
  logic [ADDRSIZE:0] wlevel_next;
  logic              wen;
  logic              wfull_next;
  logic              walmost_full_next;

  sync_r2w #(
    .ADDRSIZE (ADDRSIZE)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst     (wrst),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  // Next-pointer and status computation from the synchronized read pointer.
  always_comb begin
    wen               = winc & ~wfull;
    wbnext            = wbin + PW'(wen);
    wgnext            = PW'(bin2gray(CODE_W'(wbnext)));
    rbin_sync         = PW'(gray2bin(CODE_W'(wq2_rptr)));
    // Full when write Gray equals read Gray with the top two bits inverted,
    // i.e. the write pointer is exactly one lap ahead.
    full_gray         = wq2_rptr ^ (PW'(3) << (ADDRSIZE - 1));
    wfull_next        = (wgnext == full_gray);
    wlevel_next       = wbnext - rbin_sync;
    walmost_full_next = (wlevel_next >= PW'(AFULL_THRESH));
  end

  // Pointer and status registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbnext;
      wptr         <= wgnext;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_FULL_OVF_EN
  // Sticky overflow: a request seen while full sets it; set beats clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`else
  logic unused_wovf_clr;
  assign unused_wovf_clr = wovf_clr;
  assign wovf            = 1'b0;
`endif

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter ADDRSIZE, default 4, log2 of FIFO depth; DEPTH = 2**ADDRSIZE.
REQ-002 Parameter AFULL_THRESH, default 12, wlevel at or above which walmost_full asserts; legal range 1..DEPTH.
REQ-003 wclk  input  1  write-domain clock; only clock in the block.
REQ-004 wrst  input  1  synchronous, active-high reset, sampled on rising wclk.
REQ-005 winc  input  1  write request from producer; qualified internally by ~wfull.
REQ-006 rptr  input  ADDRSIZE+1  Gray-coded read pointer from read domain; asynchronous to wclk.
REQ-007 wovf_clr  input  1  clears sticky overflow flag.
REQ-008 waddr  output  ADDRSIZE  binary write address to memory, lower ADDRSIZE bits of binary pointer.
REQ-009 wptr  output  ADDRSIZE+1  registered Gray write pointer, exported to read domain.
REQ-010 wfull  output  1  registered full flag.
REQ-011 walmost_full  output  1  registered almost-full flag.
REQ-012 wlevel  output  ADDRSIZE+1  registered occupancy as seen from write domain, 0..DEPTH.
REQ-013 wovf  output  1  sticky overflow flag.

Function
REQ-014 rptr SHALL pass through a two-flop synchronizer on wclk; result wq2_rptr, no logic between the two flops.
REQ-015 Write enable SHALL be wen = winc & ~wfull; binary pointer wbin advances by 1 per wen, modulo 2**(ADDRSIZE+1).
REQ-016 wptr SHALL be registered Gray of next binary value: wgnext = (wbnext>>1) ^ wbnext; no combinational path from winc to wptr.
REQ-017 waddr SHALL equal wbin[ADDRSIZE-1:0]; write at waddr on an edge where wen=1, address advances at that edge.
REQ-018 wfull SHALL register (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
REQ-019 wlevel SHALL register (wbnext - gray2bin(wq2_rptr)) modulo 2**(ADDRSIZE+1); wfull=1 exactly when wlevel=DEPTH.
REQ-020 walmost_full SHALL register (next wlevel >= AFULL_THRESH); updates on same edge as wlevel.
REQ-021 Full-to-not-full latency: rptr change lands in wq2_rptr on 2nd wclk edge; wfull/wlevel/walmost_full update on 3rd edge.
REQ-022 Write while full SHALL be dropped: wbin, wptr, waddr, wlevel hold.
REQ-023 Simultaneous last write and rptr advance SHALL resolve on synchronized pointer only; wfull is pessimistic, never optimistic.
REQ-024 Pointer wrap 2**(ADDRSIZE+1)-1 -> 0 SHALL be seamless; wptr changes exactly one bit per write.

Reset
REQ-025 On wrst=1 at rising wclk: wbin=0, wptr=0, both sync flops=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
REQ-026 Reset mid-operation SHALL discard pending synchronizer contents; winc ignored during reset cycle.

Configuration
REQ-027 Macro WPTR_FULL_OVF_EN defined: wovf sets on edge after winc=1 & wfull=1, clears on wovf_clr=1; set wins over simultaneous clear.
REQ-028 Macro undefined: wovf tied 0, wovf_clr unused, no overflow register.

Structure
REQ-029 Shared package fifo_pkg SHALL hold default ADDRSIZE, gray2bin and bin2gray functions; this block and read-side logic use it.
REQ-030 Synchronizer SHALL be sub-module sync_r2w (rptr into wclk domain, sync reset active-high); all other logic in wptr_full_ctrl.

Verification
REQ-031 Reset: wrst=1 two cycles, rptr=5'b00000 -> all outputs 0, waddr=0.
REQ-032 Fill: rptr=0, winc=1 for 16 cycles -> wptr steps 1,3,2,6..., walmost_full=1 after 12th write, wfull=1 and wlevel=16 after 16th write.
REQ-033 Overflow: with full, winc=1 one more cycle -> waddr stays 0, wptr=5'b11000, wovf=1 next edge (OVF_EN); wovf_clr=1 -> wovf=0.
REQ-034 Drain visibility: full, rptr 5'b00000->5'b00001 -> wfull=0, wlevel=15 exactly 3 wclk edges later.
REQ-035 Wrap: 40 writes with rptr tracking within 4 entries -> wptr returns to 0 after 32 writes, wlevel never exceeds 4, wfull never 1.
REQ-036 Reset mid-fill: wrst=1 at wlevel=7 -> next edge all outputs 0, subsequent write goes to waddr=0.
